// File: rtl/gs_butterfly_if.sv
// rtl/gs_butterfly_if.sv - operand/result bundle for the Gentleman-Sande butterfly
interface gs_butterfly_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic [29:0]      a;
  logic [29:0]      b;
  logic [29:0]      w;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [29:0]      A;
  logic [29:0]      B;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, w, in_tag,
    input  out_valid, A, B, out_tag
  );

  modport slave (
    input  in_valid, a, b, w, in_tag,
    output out_valid, A, B, out_tag
  );
endinterface

// File: rtl/gs_butterfly.sv
// rtl/gs_butterfly.sv - pipelined Gentleman-Sande INTT butterfly with modular add/sub/mul helpers
package gs_mod_pkg;
  // Every supported prime lies in [2^29, 2^30), so one Barrett shift setup fits all of them.
  function automatic logic [29:0] mod_value(input int idx);
    case (idx)
      1:       return 30'd754974721;
      default: return 30'd998244353;
    endcase
  endfunction
endpackage

module modular_adder #(
  parameter int MOD_INDEX = 0
) (
  input  logic [29:0] x,
  input  logic [29:0] y,
  output logic [29:0] z
);
  localparam logic [30:0] QM = {1'b0, gs_mod_pkg::mod_value(MOD_INDEX)};

  logic [30:0] s;

  always_comb begin
    s = {1'b0, x} + {1'b0, y};
    z = (s >= QM) ? 30'(s - QM) : s[29:0];
  end
endmodule

module modular_subtractor #(
  parameter int MOD_INDEX = 0
) (
  input  logic [29:0] x,
  input  logic [29:0] y,
  output logic [29:0] z
);
  localparam logic [30:0] QM = {1'b0, gs_mod_pkg::mod_value(MOD_INDEX)};

  always_comb begin
    if (x >= y) z = x - y;
    else        z = 30'(({1'b0, x} + QM) - {1'b0, y});
  end
endmodule

// Four-stage Barrett multiplier: product, quotient estimate, remainder, final correction.
module modular_multiplier #(
  parameter int MOD_INDEX = 0
) (
  input  logic        clk,
  input  logic [29:0] x,
  input  logic [29:0] y,
  output logic [29:0] z
);
  localparam logic [29:0] QV   = gs_mod_pkg::mod_value(MOD_INDEX);
  localparam logic [63:0] MU_W = (64'd1 << 60) / {34'd0, QV};
  localparam logic [30:0] MU   = MU_W[30:0];
  localparam logic [31:0] Q1   = {2'd0, QV};
  localparam logic [31:0] Q2   = {1'b0, QV, 1'b0};

  logic [59:0] p_d,  p_q;
  logic [30:0] qh_d, qh_q;
  logic [31:0] pl_d, pl_q;
  logic [31:0] r_d,  r_q;
  logic [29:0] z_d,  z_q;

  always_comb begin
    p_d  = {30'd0, x} * {30'd0, y};
    qh_d = 31'(({31'd0, p_q[59:29]} * {31'd0, MU}) >> 31);
    pl_d = p_q[31:0];
    // The estimate undershoots by at most 2, so r < 3q and the low 32 bits are exact.
    r_d  = pl_q - 32'({31'd0, qh_q} * {32'd0, QV});
    if (r_q >= Q2)      z_d = 30'(r_q - Q2);
    else if (r_q >= Q1) z_d = 30'(r_q - Q1);
    else                z_d = r_q[29:0];
  end

  always_ff @(posedge clk) begin
    p_q  <= p_d;
    qh_q <= qh_d;
    pl_q <= pl_d;
    r_q  <= r_d;
    z_q  <= z_d;
  end

  assign z = z_q;
endmodule

module gs_butterfly #(
  parameter int          MOD_INDEX = 0,
  parameter int unsigned Q         = 998244353,
  parameter int          HALVE     = 1,
  parameter int          TAG_W     = 8
) (
  input logic           clk,
  input logic           rst,
  gs_butterfly_if.slave bus
);
  localparam int          MUL_LAT  = 4;
  localparam int          SB_DEPTH = 6;
  localparam logic [30:0] Q31      = 31'(Q);

  // x * 2^-1 mod q; the 31-bit sum keeps the carry of x + q before the shift.
  function automatic logic [29:0] halve(input logic [29:0] x);
    return 30'(({1'b0, x} + (x[0] ? Q31 : 31'd0)) >> 1);
  endfunction

  logic [29:0] sum_d, sum_q;
  logic [29:0] diff_d, diff_q;
  logic [29:0] w_d, w_q;
  logic [29:0] prod;
  logic [29:0] sum_dly_d [MUL_LAT];
  logic [29:0] sum_dly_q [MUL_LAT];
  logic [29:0] a_out_d, a_out_q;
  logic [29:0] b_out_d, b_out_q;
  logic [SB_DEPTH-1:0] vld_d, vld_q;
  logic [TAG_W-1:0]    tag_d [SB_DEPTH];
  logic [TAG_W-1:0]    tag_q [SB_DEPTH];

  modular_adder #(.MOD_INDEX(MOD_INDEX)) u_add (
    .x (bus.a),
    .y (bus.b),
    .z (sum_d)
  );

  modular_subtractor #(.MOD_INDEX(MOD_INDEX)) u_sub (
    .x (bus.a),
    .y (bus.b),
    .z (diff_d)
  );

  modular_multiplier #(.MOD_INDEX(MOD_INDEX)) u_mul (
    .clk (clk),
    .x   (diff_q),
    .y   (w_q),
    .z   (prod)
  );

  always_comb begin
    w_d          = bus.w;
    sum_dly_d[0] = sum_q;
    for (int i = 1; i < MUL_LAT; i++) sum_dly_d[i] = sum_dly_q[i-1];

    a_out_d = (HALVE != 0) ? halve(sum_dly_q[MUL_LAT-1]) : sum_dly_q[MUL_LAT-1];
    b_out_d = (HALVE != 0) ? halve(prod) : prod;

    vld_d    = {vld_q[SB_DEPTH-2:0], bus.in_valid};
    tag_d[0] = bus.in_tag;
    for (int i = 1; i < SB_DEPTH; i++) tag_d[i] = tag_q[i-1];
  end

  // Datapath carries no reset: a stale value is only ever seen behind out_valid = 0.
  always_ff @(posedge clk) begin
    sum_q     <= sum_d;
    diff_q    <= diff_d;
    w_q       <= w_d;
    sum_dly_q <= sum_dly_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.out_valid = vld_q[SB_DEPTH-1];
  assign bus.A         = a_out_q;
  assign bus.B         = b_out_q;
  assign bus.out_tag   = tag_q[SB_DEPTH-1];
endmodule
